// File: rtl/pwm_ramp_if.sv
// Ramp command channel: valid/ready handshake carrying target, step and rate.
// The master issues commands, the ramp controller (slave) accepts them.
interface pwm_ramp_if #(
  parameter int RATE_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_target;
  logic [7:0]        cmd_step;
  logic [RATE_W-1:0] cmd_rate;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_rate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_rate,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: free-running 256-cycle phase counter, duty moves toward a
// commanded target by a fixed step every (rate+1) periods, updates land only at phase 0.
module pwm_ramp_ctrl #(
  parameter int RATE_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          abort,
  pwm_ramp_if.slave     cmd,
  output logic [7:0]    duty_cycle,
  output logic          period_end,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic [7:0]        duty_q, duty_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        step_q, step_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              step_due;
  logic              reach;
  logic [8:0]        up_sum;
  logic [8:0]        dn_diff;
  logic [7:0]        duty_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 8'd0;
      duty_q     <= 8'd0;
      target_q   <= 8'd0;
      step_q     <= 8'd0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      rate_q     <= rate_d;
      rate_cnt_q <= rate_cnt_d;
      done_q     <= done_d;
    end
  end

  // 9-bit arithmetic so a large step saturates at the target instead of wrapping.
  always_comb begin
    up_sum    = {1'b0, duty_q} + {1'b0, step_q};
    dn_diff   = {1'b0, duty_q} - {1'b0, step_q};
    duty_next = target_q;
    if (step_q == 8'd0) begin
      duty_next = target_q;
    end else if (target_q > duty_q) begin
      duty_next = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
    end else begin
      duty_next = (dn_diff[8] || (dn_diff[7:0] <= target_q)) ? target_q : dn_diff[7:0];
    end
  end

  always_comb begin
    period_end = enable && (phase_q == 8'hFF);
    xfer       = cmd.cmd_valid && (state_q == IDLE) && !abort;
    step_due   = (state_q == RAMP) && !abort && period_end &&
                 ((step_q == 8'd0) || (rate_cnt_q >= rate_q));
    reach      = step_due && (duty_next == target_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer && (cmd.cmd_target != duty_q)) state_d = RAMP;
      RAMP: if (abort || reach) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    busy          = (state_q == RAMP);
    cmd.cmd_ready = (state_q == IDLE) && !abort;
    duty_cycle    = duty_q;
    done          = done_q;

    phase_d    = enable ? phase_q + 8'd1 : phase_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    rate_d     = rate_q;
    rate_cnt_d = rate_cnt_q;
    done_d     = 1'b0;

    if (xfer) begin
      target_d   = cmd.cmd_target;
      step_d     = cmd.cmd_step;
      rate_d     = cmd.cmd_rate;
      rate_cnt_d = '0;
      done_d     = (cmd.cmd_target == duty_q);
    end else if ((state_q == RAMP) && !abort && period_end) begin
      if (step_due) begin
        rate_cnt_d = '0;
        duty_d     = duty_next;
        done_d     = reach;
      end else begin
        rate_cnt_d = rate_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter RATE_W, default 8, width of the periods-per-step field.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  runs the phase counter and ramp; low freezes both.
REQ-005 SHALL have port cmd_valid  input  1  ramp command request.
REQ-006 SHALL have port cmd_ready  output  1  command acceptance; a transfer occurs when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_target  input  8  final duty value.
REQ-008 SHALL have port cmd_step  input  8  duty increment per step; 0 means jump.
REQ-009 SHALL have port cmd_rate  input  RATE_W  PWM periods per step minus 1.
REQ-010 SHALL have port abort  input  1  stop the ramp and hold the current duty.
REQ-011 SHALL have port duty_cycle  output  8  registered duty to the PWM datapath.
REQ-012 SHALL have port period_end  output  1  high on the last cycle of each 256-cycle PWM period.
REQ-013 SHALL have port busy  output  1  high while a ramp is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on ramp completion.

Function
REQ-015 SHALL keep an 8-bit phase counter that increments when enable=1, wraps 255->0 and holds when enable=0.
REQ-016 SHALL drive period_end = enable && phase==255 (combinational).
REQ-017 SHALL implement states IDLE and RAMP; busy = (state==RAMP).
REQ-018 SHALL drive cmd_ready = (state==IDLE) && !abort.
REQ-019 SHALL, on transfer, latch target, step and rate, clear the rate counter, and enter RAMP the next cycle.
REQ-020 SHALL, if the latched target equals duty_cycle at transfer, stay IDLE, leave duty unchanged and pulse done the next cycle.
REQ-021 SHALL, in RAMP on period_end, increment the rate counter when it is below the latched rate, else clear it and apply one duty step.
REQ-022 SHALL compute duty steps with 9-bit arithmetic: up = min(duty+step, target), down = max(duty-step, target); no wrap past 0 or 255.
REQ-023 SHALL, when step==0, set duty to target at the first period_end in RAMP regardless of rate.
REQ-024 SHALL make each duty update visible the cycle after period_end (phase==0), so a PWM counter in lockstep never sees a mid-period change.
REQ-025 SHALL, when a step makes duty equal target, enter IDLE and assert done for exactly one cycle, both on the cycle after that period_end.
REQ-026 SHALL, on abort=1 in RAMP, enter IDLE the next cycle, hold duty and suppress done; abort wins over a simultaneous period_end step.
REQ-027 SHALL ignore abort in IDLE, and SHALL NOT accept cmd_valid in the same cycle as abort.
REQ-028 SHALL, with enable=0, freeze the phase and rate counters and duty while still accepting commands.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set phase=0, rate counter=0, duty_cycle=0, state=IDLE, busy=0 and done=0, and drive cmd_ready=1 while abort=0.
REQ-030 SHALL resume counting on the first rising clk edge after rst_n deasserts; reset mid-ramp discards the command and does not pulse done.

Verification
REQ-031 Up ramp: duty 0, target 10, step 4, rate 0, enable=1 -> duty 4, 8, 10 after 3 successive period_ends; done pulses once alongside 10; busy falls with it.
REQ-032 Down ramp: duty 10, target 0, step 3, rate 1 -> duty 7, 4, 1, 0, one change every 2 periods (512 cycles), each change at phase 0.
REQ-033 Saturation and jump: duty 100, target 255, step 200 -> duty 255, no wrap. Then target 50, step 0, rate 5 -> duty 50 at the next period_end.
REQ-034 Abort and no-op: abort asserted on a period_end cycle mid-ramp -> duty unchanged, IDLE, no done. Then target equal to current duty -> done the next cycle and busy never high.
REQ-035 Freeze: enable=0 for 100 cycles mid-ramp -> phase, rate counter and duty hold, and completion is delayed by exactly 100 cycles.
REQ-036 Reset: rst_n=0 mid-ramp at duty 8 -> duty 0, busy 0, done 0 and cmd_ready 1 immediately, without a clock edge.
